// File: rtl/core_sequencer.sv
// core_sequencer: fetch/decode/execute controller for the 8-bit core.
// Optional single-step PAUSE state is enabled by defining CORE_SEQUENCER_SINGLE_STEP_EN.
module core_sequencer #(
  parameter int TIMEOUT = 15
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RUN,
  input  logic [7:0] ADDR,
  output logic [9:0] PADDR,
  output logic       PREQ,
  input  logic       PACK,
  input  logic [7:0] PDATA,
`ifdef CORE_SEQUENCER_SINGLE_STEP_EN
  input  logic       STEP_MODE,
  input  logic       STEP,
`endif
  output logic       CORE_STEP,
  output logic       MEM_INST,
  output logic       ALU_INST,
  output logic       JMP_INST,
  output logic [1:0] MS,
  output logic       IRS,
  output logic [2:0] RS,
  output logic [2:0] AR,
  output logic [2:0] BS,
  output logic [3:0] OP,
  output logic [7:0] IMM,
  output logic       HALTED,
  output logic       FAULT
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALT,
    S_FLT
`ifdef CORE_SEQUENCER_SINGLE_STEP_EN
    , S_PAUSE
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      idx_q;
  logic [7:0]      wait_q;
  logic [3:0][7:0] ir_q;
  logic            byte_ack;
  logic            sys_halt;
  logic            unused_ir;

  // Strobes as {MEM_INST, ALU_INST, JMP_INST} from instruction byte 0.
  function automatic logic [2:0] decode_strobes(input logic [7:0] b0);
    logic [1:0] cls;
    logic [1:0] ms;
    cls = b0[7:6];
    ms  = b0[5:4];
    return {(cls == 2'b01) && (ms == 2'b11), cls == 2'b00, cls == 2'b10};
  endfunction

  assign sys_halt = (ir_q[0][7:6] == 2'b11) && (ir_q[2][7:4] == 4'h1);
  assign unused_ir = ^{ir_q[1][1:0], ir_q[2][3:0]};

  assign PADDR = {ADDR, idx_q};
  assign MS    = ir_q[0][5:4];
  assign IRS   = ir_q[0][3];
  assign RS    = ir_q[0][2:0];
  assign AR    = ir_q[1][7:5];
  assign BS    = ir_q[1][4:2];
  assign OP    = ir_q[2][7:4];
  assign IMM   = ir_q[3];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
      wait_q  <= 8'd0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      if (byte_ack) begin
        ir_q[idx_q] <= PDATA;
        idx_q       <= idx_q + 2'd1;
        wait_q      <= 8'd0;
      end else if (state_q == S_FETCH && wait_q != TIMEOUT_CNT) begin
        wait_q <= wait_q + 8'd1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    byte_ack  = 1'b0;
    PREQ      = 1'b0;
    CORE_STEP = 1'b0;
    MEM_INST  = 1'b0;
    ALU_INST  = 1'b0;
    JMP_INST  = 1'b0;
    HALTED    = 1'b0;
    FAULT     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (RUN) state_d = S_FETCH;
      end
      S_FETCH: begin
        PREQ = 1'b1;
        if (PACK) begin
          byte_ack = 1'b1;
          if (idx_q == 2'd3) begin
`ifdef CORE_SEQUENCER_SINGLE_STEP_EN
            state_d = STEP_MODE ? S_PAUSE : S_EXEC;
`else
            state_d = S_EXEC;
`endif
          end
        end else if (wait_q == TIMEOUT_CNT) begin
          state_d = S_FLT;
        end
      end
`ifdef CORE_SEQUENCER_SINGLE_STEP_EN
      S_PAUSE: begin
        if (STEP) state_d = S_EXEC;
      end
`endif
      S_EXEC: begin
        CORE_STEP = 1'b1;
        {MEM_INST, ALU_INST, JMP_INST} = decode_strobes(ir_q[0]);
        // The index has already wrapped to 0, so the next fetch starts at byte 0 of the new ADDR.
        state_d = sys_halt ? S_HALT : S_FETCH;
      end
      S_HALT: begin
        HALTED = 1'b1;
        if (RUN) state_d = S_FETCH;
      end
      S_FLT: begin
        FAULT = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: the bench plays program memory and the core (instruction pointer),
// and checks each instruction transaction against the instruction format and class rules.
module tb_core_sequencer;
  localparam int TIMEOUT = 15;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RUN = 1'b0;
  logic       PACK = 1'b0;
  logic [7:0] ADDR = 8'h00;
  logic [7:0] PDATA = 8'h00;
  logic [9:0] PADDR;
  logic       PREQ, CORE_STEP, MEM_INST, ALU_INST, JMP_INST, IRS, HALTED, FAULT;
  logic [1:0] MS;
  logic [2:0] RS, AR, BS;
  logic [3:0] OP;
  logic [7:0] IMM;
`ifdef CORE_SEQUENCER_SINGLE_STEP_EN
  logic       STEP_MODE = 1'b0;
  logic       STEP = 1'b0;
`endif

  int         total = 0;
  int         bad = 0;
  logic [7:0] addr_m = 8'h00;

  always #5 CLK = ~CLK;

  core_sequencer #(.TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST), .RUN(RUN), .ADDR(ADDR), .PADDR(PADDR), .PREQ(PREQ),
    .PACK(PACK), .PDATA(PDATA),
`ifdef CORE_SEQUENCER_SINGLE_STEP_EN
    .STEP_MODE(STEP_MODE), .STEP(STEP),
`endif
    .CORE_STEP(CORE_STEP), .MEM_INST(MEM_INST), .ALU_INST(ALU_INST), .JMP_INST(JMP_INST),
    .MS(MS), .IRS(IRS), .RS(RS), .AR(AR), .BS(BS), .OP(OP), .IMM(IMM),
    .HALTED(HALTED), .FAULT(FAULT)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {MEM_INST, ALU_INST, JMP_INST} required for an instruction word (byte 0 in bits 7:0).
  function automatic logic [2:0] exp_strobes(input logic [31:0] ins);
    logic [1:0] cls;
    cls = ins[7:6];
    if (cls == 2'b00) return 3'b010;
    if (cls == 2'b10) return 3'b001;
    if (cls == 2'b01 && ins[5:4] == 2'b11) return 3'b100;
    return 3'b000;
  endfunction

  function automatic logic [23:0] exp_fields(input logic [31:0] ins);
    return {ins[5:4], ins[3], ins[2:0], ins[15:13], ins[12:10], ins[23:20], ins[31:24]};
  endfunction

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1; RUN = 1'b0; PACK = 1'b0; #1;
    chk("rst_preq", PREQ, 0);
    chk("rst_quiet", {CORE_STEP, MEM_INST, ALU_INST, JMP_INST, HALTED, FAULT}, 0);
    chk("rst_fields", {MS, IRS, RS, AR, BS, OP, IMM}, 0);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic start_run();
    @(negedge CLK);
    RUN = 1'b0; ADDR = addr_m; #1;
    chk("idle_preq", PREQ, 0);
    @(negedge CLK);
    RUN = 1'b1; #1;
    chk("idle_run_preq", PREQ, 0);
  endtask

  // One instruction: w0..w3 wait cycles per byte, taken = core takes a jump, rx = RUN during EXEC.
  task automatic run_instr(input logic [31:0] ins, input int w0, input int w1, input int w2,
                           input int w3, input bit taken, input bit rx);
    int  w[4];
    bit  halt;
    w = '{w0, w1, w2, w3};
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < w[i]; k++) begin
        @(negedge CLK);
        PACK = 1'b0; PDATA = 8'($urandom); RUN = 1'($urandom); #1;
        chk("wait_preq", PREQ, 1);
        chk("wait_paddr", PADDR, {addr_m, i[1:0]});
        chk("wait_step", CORE_STEP, 0);
      end
      @(negedge CLK);
      PACK = 1'b1; PDATA = ins[8*i +: 8]; RUN = 1'b0; #1;
      chk("fetch_preq", PREQ, 1);
      chk("fetch_paddr", PADDR, {addr_m, i[1:0]});
      chk("fetch_step", CORE_STEP, 0);
      chk("fetch_fault", FAULT, 0);
      if (i == 1) chk("b0_latched_rs", RS, ins[2:0]);
    end
    @(negedge CLK);
    PACK = 1'b0; RUN = rx; #1;
    chk("exec_step", CORE_STEP, 1);
    chk("exec_preq", PREQ, 0);
    chk("exec_strobes", {MEM_INST, ALU_INST, JMP_INST}, exp_strobes(ins));
    chk("exec_fields", {MS, IRS, RS, AR, BS, OP, IMM}, exp_fields(ins));
    halt = (ins[7:6] == 2'b11) && (ins[23:20] == 4'h1);
    addr_m = (ins[7:6] == 2'b10 && taken) ? ins[31:24] : addr_m + 8'd1;
    @(negedge CLK);
    ADDR = addr_m; #1;
    chk("post_step", CORE_STEP, 0);
    chk("post_strobes", {MEM_INST, ALU_INST, JMP_INST}, 0);
    if (halt) begin
      chk("halt_halted", HALTED, 1);
      chk("halt_preq", PREQ, 0);
      if (!rx) begin
        @(negedge CLK);
        RUN = 1'b1; #1;
        chk("halt_wait_halted", HALTED, 1);
        chk("halt_wait_preq", PREQ, 0);
      end
    end else begin
      RUN = 1'b0;
      chk("next_preq", PREQ, 1);
      chk("next_paddr", PADDR, {addr_m, 2'b00});
      chk("next_halted", HALTED, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] ins;
    do_reset();
    addr_m = 8'h05;
    start_run();
    run_instr(32'h0030_4407, 0, 0, 0, 0, 0, 0);   // ALU: RS=7 AR=2 BS=1 OP=3
    run_instr(32'h0010_00C0, 0, 0, 0, 0, 0, 0);   // SYS HALT, RUN pulse afterwards
    run_instr(32'h0010_00C5, 1, 0, 2, 0, 0, 1);   // SYS HALT with RUN high during EXEC
    run_instr(32'h0000_0070, 0, 1, 0, 0, 0, 0);   // memory access
    run_instr(32'h5A00_0040, 0, 0, 0, 3, 0, 0);   // register/immediate move
    run_instr(32'h0020_00C0, 0, 0, 0, 0, 0, 0);   // SYS NOP
    run_instr(32'h2000_0080, 0, 0, 0, 0, 1, 0);   // JMP taken to 0x20
    run_instr(32'h4400_0080, 0, 0, 0, 0, 0, 0);   // JMP not taken
    run_instr(32'hA5F0_FC3B, 14, 15, 15, 15, 0, 0); // PACK in the 16th waiting cycle
    for (int n = 0; n < 40; n++) begin
      ins = $urandom;
      if ($urandom_range(0, 7) == 0) begin
        ins[7:6] = 2'b11;
        ins[23:20] = 4'h1;
      end
      run_instr(ins, $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 3),
                ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 2),
                1'($urandom), 1'($urandom));
    end

    // Reset while fetching byte 2 discards the partial instruction.
    do_reset();
    addr_m = 8'h30;
    start_run();
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      PACK = 1'b1; PDATA = (i == 0) ? 8'h07 : 8'h44; RUN = 1'b0; #1;
    end
    @(negedge CLK);
    PACK = 1'b0; #1;
    chk("mid_preq", PREQ, 1);
    chk("mid_paddr", PADDR, {addr_m, 2'b10});
    chk("mid_rs_before", RS, 3'd7);
    #2 RST = 1'b1; #1;
    chk("mid_rst_preq", PREQ, 0);
    chk("mid_rst_fields", {MS, IRS, RS, AR, BS, OP, IMM}, 0);
    @(negedge CLK);
    RST = 1'b0;
    start_run();
    run_instr(32'h0000_4802, 0, 0, 0, 0, 0, 0);

    // Fetch that is never acknowledged ends in a sticky fault.
    do_reset();
    start_run();
    for (int k = 0; k < TIMEOUT + 1; k++) begin
      @(negedge CLK);
      PACK = 1'b0; RUN = 1'b0; #1;
      chk("to_preq", PREQ, 1);
      chk("to_fault", FAULT, 0);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      PACK = 1'b1; RUN = 1'b1; #1;
      chk("flt_fault", FAULT, 1);
      chk("flt_preq", PREQ, 0);
      chk("flt_step", CORE_STEP, 0);
    end

`ifdef CORE_SEQUENCER_SINGLE_STEP_EN
    do_reset();
    STEP_MODE = 1'b1;
    start_run();
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      PACK = 1'b1; PDATA = 8'h07; RUN = 1'b0; #1;
      chk("ss_fetch_preq", PREQ, 1);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      PACK = 1'b0; STEP = 1'b0; #1;
      chk("ss_pause_step", CORE_STEP, 0);
      chk("ss_pause_preq", PREQ, 0);
    end
    @(negedge CLK);
    STEP = 1'b1; #1;
    chk("ss_stepin_step", CORE_STEP, 0);
    @(negedge CLK);
    STEP = 1'b0; #1;
    chk("ss_exec_step", CORE_STEP, 1);
    chk("ss_exec_alu", ALU_INST, 1);
    @(negedge CLK);
    #1;
    chk("ss_after_step", CORE_STEP, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
- Fetch/decode/execute controller for the 8-bit core; the core has no internal control logic of its own.
- Fetches a 4-byte instruction from byte-wide program memory at the core's current Addr and latches it into an instruction register (IR).
- Drives the core's control lines from the IR and issues a one-cycle CORE_STEP. Top level uses CORE_STEP to enable the core's clock, so the register bank, FLAGS and instruction pointer advance exactly once per instruction.

Parameters:
- TIMEOUT, 15, maximum PACK wait count per byte before FAULT (1..255).

Ports:
- CLK in 1: system clock; all state changes on the rising edge.
- RST in 1: asynchronous, active-high reset.
- RUN in 1: leaves IDLE/HALT when sampled high.
- ADDR in 8: core instruction pointer (core Addr output).
- PADDR out 10: program byte address {ADDR, byte index[1:0]}.
- PREQ out 1: program memory read request.
- PACK in 1: read acknowledge; PDATA is valid in the same cycle.
- PDATA in 8: program byte.
- CORE_STEP out 1: core clock enable, high for exactly one cycle per instruction.
- MEM_INST, ALU_INST, JMP_INST out 1 each: decoded strobes, high only while CORE_STEP is high.
- MS out 2: {MS1,MS0}.
- IRS out 1.
- RS out 3: {RS2,RS1,RS0}.
- AR out 3: {AR2,AR1,AR0}.
- BS out 3: {BS2,BS1,BS0}.
- OP out 4.
- IMM out 8.
- HALTED out 1: in HALT state.
- FAULT out 1: fetch timeout occurred; sticky until RST.

Behaviour:
- Instruction format (bytes in index order):
  - b0 = {CLASS[1:0], MS[1:0], IRS, RS[2:0]}
  - b1 = {AR[2:0], BS[2:0], 2'b00}
  - b2 = {OP[3:0], 4'b0000}
  - b3 = IMM
- Reset:
  - State goes to IDLE.
  - IR cleared, so all field outputs are 0.
  - PREQ, CORE_STEP, all strobes, HALTED and FAULT are 0.
  - PREQ drops asynchronously, including when RST asserts mid-fetch; a partially fetched instruction is discarded.
- States: IDLE, FETCH (byte index 0..3), EXEC, HALT, FLT.
- IDLE:
  - Outputs quiet.
  - RUN=1 → FETCH, index 0.
- FETCH:
  - PREQ=1 and PADDR={ADDR, index}, both held stable until PACK.
  - On a PACK=1 edge: PDATA is latched into IR byte[index], the wait counter clears, and index increments.
  - After index 3 is accepted → EXEC.
  - PREQ may stay high across consecutive bytes.
  - Field outputs update only when a byte is latched; they are stable through EXEC.
- Wait counter:
  - Counts cycles with PREQ=1 and PACK=0.
  - A PACK arriving while the count is ≤ TIMEOUT is accepted.
  - If PACK=0 while the count equals TIMEOUT → FLT.
- EXEC (exactly one cycle):
  - CORE_STEP=1.
  - ALU_INST = (CLASS==00).
  - MEM_INST = (CLASS==01 && MS==11).
  - JMP_INST = (CLASS==10).
  - CLASS 01 with MS≠11 asserts no strobe (register/immediate move); the core still steps.
  - CLASS 11 is SYS: OP=0001 is HALT; every other OP is NOP. SYS asserts no strobes, but CORE_STEP still pulses so the instruction pointer advances.
  - Next state: SYS-HALT → HALT; otherwise → FETCH, index 0, using the updated ADDR.
- Latency: with zero-wait memory (PACK tied high), each instruction takes 5 cycles: 4 fetch + 1 exec. Each wait cycle adds one.
- HALT:
  - HALTED=1, PREQ=0.
  - RUN=1 → FETCH at the already-advanced ADDR.
  - If RUN is held high during EXEC of a HALT, HALT still lasts at least one cycle.
- FLT:
  - FAULT=1, PREQ=0, CORE_STEP=0.
  - Only RST exits.
- Jumps: the sequencer never computes addresses. Branch resolution is the core's own PL_E/instruction-pointer logic on the CORE_STEP edge.
- Unused IR bits are ignored.
- ADDR changes outside EXEC are not expected. PADDR tracks ADDR combinationally.

Optional Feature:
- Macro: CORE_SEQUENCER_SINGLE_STEP_EN.
- When defined:
  - Adds input ports STEP_MODE (1) and STEP (1), and a PAUSE state between FETCH and EXEC.
  - With STEP_MODE=1, after byte 3 the FSM enters PAUSE (outputs as in FETCH end, PREQ=0).
  - It moves to EXEC on the first cycle STEP=1.
  - With STEP_MODE=0, behaviour is identical to the undefined build.
- When undefined: no extra ports and no PAUSE state.

Test Plan:
- Reset then RUN=1, PACK tied 1, ADDR=0x05, bytes {0x07,0x44,0x30,0x00} → PADDR 0x014..0x017 on consecutive cycles; EXEC in cycle 5 with CORE_STEP=1, ALU_INST=1, RS=7, AR=2, BS=1, OP=3.
- SYS HALT (b0=0xC0, b2=0x10) → one CORE_STEP with no strobes, then HALTED=1 and PREQ=0; RUN pulse → fetch resumes at PADDR {ADDR+1, 00}.
- TIMEOUT=15, PACK first asserted in the 16th waiting cycle → byte accepted with no FAULT; PACK never asserted → FAULT=1 on the edge after count 15, and no CORE_STEP afterwards.
- RST asserted while fetching byte 2 → PREQ=0 immediately and IR=0; after RUN, fetch restarts at index 0.
- JMP instruction (b0=0x80, IMM=0x20) → JMP_INST=1 only in the EXEC cycle; after the step, next fetch uses whatever ADDR the core presents (0x20 if taken).
- With CORE_SEQUENCER_SINGLE_STEP_EN, STEP_MODE=1 → FSM stalls in PAUSE with CORE_STEP=0 until STEP=1, then exactly one CORE_STEP.
